// File: rtl/psum_acc_buf_if.sv
// Request, read and result channels of the partial-sum accumulation buffer.
// The master drives requests; the slave (the buffer) answers with ready and read data.
interface psum_acc_buf_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 2048
);
   localparam int AW = $clog2(depth);
   localparam int W  = col * psum_bw;

   logic          in_valid;
   logic          in_ready;
   logic          in_mode;
   logic [AW-1:0] in_addr;
   logic [W-1:0]  in_data;

   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_addr;
   logic          relu_en;

   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;

   modport master (
      output in_valid, in_mode, in_addr, in_data,
      output rd_valid, rd_addr, relu_en, out_ready,
      input  in_ready, rd_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_mode, in_addr, in_data,
      input  rd_valid, rd_addr, relu_en, out_ready,
      output in_ready, rd_ready, out_valid, out_data
   );
endinterface

// File: rtl/psum_acc_buf.sv
// Partial-sum buffer: overwrite or saturating-accumulate words, read with optional ReLU,
// and a zeroing sweep after reset or on clr.
module psum_acc_buf #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 2048
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clr,
   output logic           busy,
   psum_acc_buf_if.slave  bus
);
   localparam int AW = $clog2(depth);
   localparam int W  = col * psum_bw;
   localparam logic [AW-1:0] LAST = AW'(depth - 1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] cnt;
   logic [W-1:0]  mem [depth];

   logic          acc_valid;
   logic [AW-1:0] acc_addr;
   logic [W-1:0]  acc_data, acc_old, acc_sum, acc_src;
   logic          in_fire, rd_fire;
   logic [W-1:0]  rd_word, rd_out;

   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0]       r;
      logic [psum_bw:0]   s;
      r = '0;
      for (int k = 0; k < col; k++) begin
         s = {a[k*psum_bw + psum_bw - 1], a[k*psum_bw +: psum_bw]}
           + {b[k*psum_bw + psum_bw - 1], b[k*psum_bw +: psum_bw]};
         // Top two bits of the widened sum disagree exactly on overflow.
         if (s[psum_bw] != s[psum_bw-1])
            r[k*psum_bw +: psum_bw] = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                                 : {1'b0, {(psum_bw-1){1'b1}}};
         else
            r[k*psum_bw +: psum_bw] = s[psum_bw-1:0];
      end
      return r;
   endfunction

   function automatic logic [W-1:0] relu(input logic [W-1:0] a);
      logic [W-1:0] r;
      r = a;
      for (int k = 0; k < col; k++)
         if (a[k*psum_bw + psum_bw - 1]) r[k*psum_bw +: psum_bw] = '0;
      return r;
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx     = state;
      busy         = 1'b0;
      bus.in_ready = 1'b0;
      bus.rd_ready = 1'b0;
      case (state)
         CLEAR: begin
            busy = 1'b1;
            if (cnt == LAST) state_nx = IDLE;
         end
         IDLE: begin
            bus.in_ready = 1'b1;
            bus.rd_ready = !bus.out_valid || bus.out_ready;
            if (clr) state_nx = CLEAR;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == CLEAR) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign in_fire = bus.in_valid && bus.in_ready;
   assign rd_fire = bus.rd_valid && bus.rd_ready;
   assign acc_sum = sat_add(acc_old, acc_data);

   // Stage-1 operand and read data both see writes landing at the same edge.
   assign acc_src = (acc_valid && acc_addr == bus.in_addr) ? acc_sum : mem[bus.in_addr];

   always_comb begin
      rd_word = mem[bus.rd_addr];
      if (in_fire && !bus.in_mode && bus.in_addr == bus.rd_addr) rd_word = bus.in_data;
      else if (acc_valid && acc_addr == bus.rd_addr)              rd_word = acc_sum;
   end

   assign rd_out = bus.relu_en ? relu(rd_word) : rd_word;

   // NOTE: storage and datapath registers carry no reset; the clear sweep initialises the array.
   always_ff @(posedge clk) begin
      if (acc_valid)                    mem[acc_addr]    <= acc_sum;
      if (state == CLEAR)               mem[cnt]         <= '0;
      if (in_fire && !bus.in_mode)      mem[bus.in_addr] <= bus.in_data;
      if (in_fire && bus.in_mode) begin
         acc_addr <= bus.in_addr;
         acc_data <= bus.in_data;
         acc_old  <= acc_src;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_valid     <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else begin
         acc_valid <= in_fire && bus.in_mode;
         if (rd_fire) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= rd_out;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_psum_acc_buf.sv
// Scoreboard bench for psum_acc_buf: expected read words are queued at read accept
// and compared when the result is consumed.
module tb_psum_acc_buf;
   localparam int COL = 4, BW = 8, DEPTH = 16, AW = 4, W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clr = 1'b0;
   logic busy;

   psum_acc_buf_if #(.col(COL), .psum_bw(BW), .depth(DEPTH)) bus ();

   psum_acc_buf #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] mdl [DEPTH];

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
      logic [W-1:0] w;
      w[7:0]   = l0[7:0];
      w[15:8]  = l1[7:0];
      w[23:16] = l2[7:0];
      w[31:24] = l3[7:0];
      return w;
   endfunction

   function automatic logic [W-1:0] sat4(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] w;
      int x;
      for (int k = 0; k < COL; k++) begin
         x = $signed(a[k*8 +: 8]) + $signed(b[k*8 +: 8]);
         if (x > 127)  x = 127;
         if (x < -128) x = -128;
         w[k*8 +: 8] = x[7:0];
      end
      return w;
   endfunction

   function automatic logic [W-1:0] relu4(input logic [W-1:0] a);
      logic [W-1:0] w;
      w = a;
      for (int k = 0; k < COL; k++)
         if (a[k*8 + 7]) w[k*8 +: 8] = 8'd0;
      return w;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic mode, input int addr, input logic [W-1:0] data);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_mode  = mode;
      bus.in_addr  = addr[AW-1:0];
      bus.in_data  = data;
      while (!bus.in_ready && n < 100) begin cycle(); n++; end
      if (!bus.in_ready) check("wr_timeout", 32'd0, 32'd1);
      else mdl[addr] = mode ? sat4(mdl[addr], data) : data;
      cycle();
      bus.in_valid = 1'b0;
   endtask

   task automatic rd(input int addr, input logic relu_on, input logic [W-1:0] exp);
      int n = 0;
      bus.rd_valid = 1'b1;
      bus.rd_addr  = addr[AW-1:0];
      bus.relu_en  = relu_on;
      while (!bus.rd_ready && n < 100) begin cycle(); n++; end
      if (!bus.rd_ready) check("rd_timeout", 32'd0, 32'd1);
      else exp_q.push_back(exp);
      cycle();
      bus.rd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin cycle(); n++; end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Counts busy cycles; optional clr pulse and out_ready release at given cycle indices.
   task automatic wait_sweep(input int clr_at, input int rel_at, output int n, output logic bad);
      n = 0;
      bad = 1'b0;
      while (busy && n < 100) begin
         if (bus.in_ready || bus.rd_ready) bad = 1'b1;
         clr = (n == clr_at);
         if (n == rel_at) bus.out_ready = 1'b1;
         cycle();
         n++;
      end
      clr = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
         else check("out_data", bus.out_data, exp_q.pop_front());
      end
   end

   initial begin
      int   n;
      logic bad;
      int   a;
      logic [W-1:0] d;
      logic rl;

      bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_addr = '0; bus.in_data = '0;
      bus.rd_valid = 1'b0; bus.rd_addr = '0;   bus.relu_en = 1'b0; bus.out_ready = 1'b1;

      // Reset state
      repeat (3) cycle();
      check("rst_busy",      32'(busy),          32'd1);
      check("rst_in_ready",  32'(bus.in_ready),  32'd0);
      check("rst_rd_ready",  32'(bus.rd_ready),  32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  bus.out_data,       32'd0);
      reset = 1'b0;
      wait_sweep(-1, -1, n, bad);
      check("init_sweep_len", 32'(n), 32'd16);
      check("init_sweep_rdy", 32'(bad), 32'd0);
      check("init_in_ready",  32'(bus.in_ready), 32'd1);
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

      for (int i = 0; i < DEPTH; i++) rd(i, 1'b0, 32'd0);
      drain();

      // Overwrite then two back-to-back accumulates; read lands on the last write edge
      wr(1'b0, 3, pack4(5, -2, 7, 0));
      wr(1'b1, 3, pack4(1, 1, 1, 1));
      wr(1'b1, 3, pack4(1, 1, 1, 1));
      rd(3, 1'b0, pack4(7, 0, 9, 2));

      // Saturation at both ends
      wr(1'b1, 5, pack4(120, -120, 0, 0));
      wr(1'b1, 5, pack4(20, -20, 0, 0));
      rd(5, 1'b0, pack4(127, -128, 0, 0));

      // ReLU on read only
      wr(1'b0, 7, pack4(-4, 9, -1, 3));
      rd(7, 1'b1, pack4(0, 9, 0, 3));
      rd(7, 1'b0, pack4(-4, 9, -1, 3));
      drain();

      // Back-pressure: result holds, no new read accepted
      bus.out_ready = 1'b0;
      rd(3, 1'b0, pack4(7, 0, 9, 2));
      for (int i = 0; i < 5; i++) begin
         check("hold_valid",    32'(bus.out_valid), 32'd1);
         check("hold_data",     bus.out_data,       pack4(7, 0, 9, 2));
         check("hold_rd_ready", 32'(bus.rd_ready),  32'd0);
         cycle();
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_rd_ready", 32'(bus.rd_ready), 32'd1);
      rd(5, 1'b0, pack4(127, -128, 0, 0));
      drain();

      // Same-cycle overwrite and read of one address
      check("same_in_ready", 32'(bus.in_ready), 32'd1);
      check("same_rd_ready", 32'(bus.rd_ready), 32'd1);
      bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_addr = 4'd9; bus.in_data = pack4(11, -12, 13, -14);
      bus.rd_valid = 1'b1; bus.rd_addr = 4'd9; bus.relu_en = 1'b0;
      exp_q.push_back(pack4(11, -12, 13, -14));
      mdl[9] = pack4(11, -12, 13, -14);
      cycle();
      bus.in_valid = 1'b0; bus.rd_valid = 1'b0;
      wr(1'b1, 9, pack4(1, 1, 1, 1));
      rd(9, 1'b0, pack4(12, -11, 14, -13));
      drain();

      // Random mix on a few addresses against the bench model
      for (int i = 0; i < 24; i++) begin
         a = 10 + int'($urandom_range(0, 3));
         d = $urandom();
         wr(1'($urandom_range(0, 1)), a, d);
      end
      for (int i = 10; i < 14; i++) begin
         rl = 1'($urandom_range(0, 1));
         rd(i, rl, rl ? relu4(mdl[i]) : mdl[i]);
      end
      drain();

      // Clear with a pending result and an accumulate in stage 2
      wr(1'b0, 3, pack4(1, 2, 3, 4));
      bus.out_ready = 1'b0;
      rd(7, 1'b0, pack4(-4, 9, -1, 3));
      check("clr_acc_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1; bus.in_mode = 1'b1; bus.in_addr = 4'd3; bus.in_data = pack4(1, 1, 1, 1);
      cycle();
      bus.in_valid = 1'b0;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      check("clr_busy", 32'(busy), 32'd1);
      wait_sweep(5, 8, n, bad);
      check("clr_sweep_len", 32'(n), 32'd16);
      check("clr_sweep_rdy", 32'(bad), 32'd0);
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      rd(3, 1'b0, 32'd0);
      rd(7, 1'b0, 32'd0);
      rd(0, 1'b0, 32'd0);
      drain();

      // Asynchronous reset in the middle of a sweep drops the pending result and restarts
      bus.out_ready = 1'b0;
      rd(5, 1'b0, 32'd0);
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      repeat (5) cycle();
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy",      32'(busy),          32'd1);
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_out_data",  bus.out_data,       32'd0);
      exp_q.delete();
      bus.out_ready = 1'b1;
      cycle();
      reset = 1'b0;
      wait_sweep(-1, -1, n, bad);
      check("arst_sweep_len", 32'(n), 32'd16);
      check("arst_in_ready",  32'(bus.in_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
